// File: rtl/pong_pkg.sv
// Shared encodings and default tuning for the pong game-flow controller.
// Imported by the interface, the score counter and the flow controller.
package pong_pkg;

  localparam int DIGIT_W = 4;
  localparam int SCORE_W = 4 * DIGIT_W;

  localparam int DEF_LIVES         = 3;
  localparam int DEF_SERVE_FRAMES  = 60;
  localparam int DEF_MISS_FRAMES   = 63;
  localparam int DEF_HITS_PER_STEP = 8;
  localparam int DEF_MAX_SPEED     = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

endpackage

// File: rtl/pong_flow_ctrl_if.sv
// Event and control bundle between the pong datapath and the flow controller.
// master = datapath side (drives events), slave = flow controller.
interface pong_flow_ctrl_if;
  import pong_pkg::*;

  logic               end_of_frame;
  logic               start_btn;
  logic               paddle_hit;
  logic               ball_missed;
  logic               ball_enable;
  logic               ball_load;
  logic [1:0]         speed;
  logic [1:0]         lives;
  logic [SCORE_W-1:0] score;
  logic               miss_flash;
  logic               game_over;
  logic [2:0]         state_dbg;

  modport master (
    output end_of_frame, start_btn,
    output paddle_hit, ball_missed,
    input  ball_enable, ball_load,
    input  speed, lives, score,
    input  miss_flash, game_over,
    input  state_dbg
  );

  modport slave (
    input  end_of_frame, start_btn,
    input  paddle_hit, ball_missed,
    output ball_enable, ball_load,
    output speed, lives, score,
    output miss_flash, game_over,
    output state_dbg
  );

endinterface

// File: rtl/pong_bcd_score.sv
// Four-digit BCD score counter; holds at 9999 instead of wrapping.
// clr has priority over inc.
module pong_bcd_score
  import pong_pkg::*;
(
  input  logic               clk25,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] score
);

  logic [SCORE_W-1:0] w_next;
  logic               w_full;

  // ripple the +1 through digits until one absorbs the carry
  always_comb begin
    logic c;
    w_next = score;
    c      = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (score[d*DIGIT_W +: DIGIT_W] == 4'd9) begin
          w_next[d*DIGIT_W +: DIGIT_W] = 4'd0;
        end else begin
          w_next[d*DIGIT_W +: DIGIT_W] =
            score[d*DIGIT_W +: DIGIT_W] + 4'd1;
          c = 1'b0;
        end
      end
    end
  end

  assign w_full = (score == 16'h9999);

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      score <= '0;
    end else if (clr) begin
      score <= '0;
    end else if (inc && !w_full) begin
      score <= w_next;
    end
  end

endmodule

// File: rtl/pong_flow_ctrl.sv
// Game-flow sequencer: attract, serve, play, miss flash and game over.
// Gates ball motion, counts lives, ramps speed and drives the score.
module pong_flow_ctrl
  import pong_pkg::*;
#(
  parameter int LIVES         = DEF_LIVES,
  parameter int SERVE_FRAMES  = DEF_SERVE_FRAMES,
  parameter int MISS_FRAMES   = DEF_MISS_FRAMES,
  parameter int HITS_PER_STEP = DEF_HITS_PER_STEP,
  parameter int MAX_SPEED     = DEF_MAX_SPEED
) (
  input  logic            clk25,
  input  logic            reset_n,
  pong_flow_ctrl_if.slave bus
);

  state_t     r_state,     w_state_nx;
  logic [7:0] r_frame_cnt, w_frame_nx;
  logic [7:0] r_hit_cnt,   w_hit_nx;
  logic [1:0] r_lives,     w_lives_nx;
  logic [1:0] r_speed,     w_speed_nx;
  logic       r_en,        w_en_nx;
  logic       r_load,      w_load_nx;
  logic       r_flash,     w_flash_nx;
  logic       r_over,      w_over_nx;

  logic       r_sync1, r_sync2, r_start_q;
  logic       w_start_edge;
  logic       w_clr, w_inc, w_last;
  logic [7:0] w_hit_inc;
  logic [SCORE_W-1:0] w_score;

  assign w_start_edge = r_sync2 & ~r_start_q;
  assign w_last       = (r_frame_cnt <= 8'd1);
  assign w_hit_inc    = r_hit_cnt + 8'd1;

  always_comb begin
    w_state_nx = r_state;
    w_frame_nx = r_frame_cnt;
    w_hit_nx   = r_hit_cnt;
    w_lives_nx = r_lives;
    w_speed_nx = r_speed;
    w_en_nx    = r_en;
    w_load_nx  = 1'b0;
    w_flash_nx = r_flash;
    w_over_nx  = r_over;
    w_clr      = 1'b0;
    w_inc      = 1'b0;
    unique case (1'b1)
      (r_state == ST_IDLE),
      (r_state == ST_OVER): begin
        w_en_nx = 1'b0;
        if (w_start_edge) begin
          w_state_nx = ST_SERVE;
          w_load_nx  = 1'b1;
          w_lives_nx = 2'(LIVES);
          w_speed_nx = 2'd0;
          w_hit_nx   = 8'd0;
          w_frame_nx = 8'(SERVE_FRAMES);
          w_over_nx  = 1'b0;
          w_clr      = 1'b1;
        end
      end
      (r_state == ST_SERVE): begin
        w_en_nx = 1'b0;
        if (bus.end_of_frame) begin
          if (w_last) begin
            w_state_nx = ST_PLAY;
            w_en_nx    = 1'b1;
            w_frame_nx = 8'd0;
          end else begin
            w_frame_nx = r_frame_cnt - 8'd1;
          end
        end
      end
      (r_state == ST_PLAY): begin
        w_en_nx = 1'b1;
        // a miss in the same cycle as a hit cancels the hit
        if (bus.ball_missed) begin
          w_state_nx = ST_MISS;
          w_lives_nx = r_lives - 2'd1;
          w_frame_nx = 8'(MISS_FRAMES);
          w_flash_nx = 1'b1;
          w_en_nx    = 1'b0;
        end else if (bus.paddle_hit) begin
          w_inc = 1'b1;
          if (w_hit_inc == 8'(HITS_PER_STEP)) begin
            w_hit_nx = 8'd0;
            if (r_speed < 2'(MAX_SPEED)) begin
              w_speed_nx = r_speed + 2'd1;
            end
          end else begin
            w_hit_nx = w_hit_inc;
          end
        end
      end
      (r_state == ST_MISS): begin
        w_flash_nx = 1'b1;
        if (bus.end_of_frame) begin
          if (w_last) begin
            w_flash_nx = 1'b0;
            if (r_lives == 2'd0) begin
              w_state_nx = ST_OVER;
              w_over_nx  = 1'b1;
              w_frame_nx = 8'd0;
            end else begin
              w_state_nx = ST_SERVE;
              w_load_nx  = 1'b1;
              w_frame_nx = 8'(SERVE_FRAMES);
            end
          end else begin
            w_frame_nx = r_frame_cnt - 8'd1;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_en_nx    = 1'b0;
        w_flash_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= 8'd0;
      r_hit_cnt   <= 8'd0;
      r_lives     <= 2'(LIVES);
      r_speed     <= 2'd0;
      r_en        <= 1'b0;
      r_load      <= 1'b0;
      r_flash     <= 1'b0;
      r_over      <= 1'b0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_start_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_frame_cnt <= w_frame_nx;
      r_hit_cnt   <= w_hit_nx;
      r_lives     <= w_lives_nx;
      r_speed     <= w_speed_nx;
      r_en        <= w_en_nx;
      r_load      <= w_load_nx;
      r_flash     <= w_flash_nx;
      r_over      <= w_over_nx;
      r_sync1     <= bus.start_btn;
      r_sync2     <= r_sync1;
      r_start_q   <= r_sync2;
    end
  end

  pong_bcd_score u_score (
    .clk25   (clk25),
    .reset_n (reset_n),
    .clr     (w_clr),
    .inc     (w_inc),
    .score   (w_score)
  );

  assign bus.ball_enable = r_en;
  assign bus.ball_load   = r_load;
  assign bus.speed       = r_speed;
  assign bus.lives       = r_lives;
  assign bus.score       = w_score;
  assign bus.miss_flash  = r_flash;
  assign bus.game_over   = r_over;
  assign bus.state_dbg   = r_state;

endmodule
